// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared widths and state encoding for the IF/MEM RAM arbiter
package mem_arbiter_pkg;

    localparam int ARB_ADDR_W = 32;
    localparam int ARB_DATA_W = 32;
    localparam int ARB_SEL_W  = ARB_DATA_W / 8;

    // Arbiter FSM states; two bits leave room for one more state
    typedef enum logic [1:0] {
        ARB_IDLE     = 2'd0,
        ARB_BUSY_MEM = 2'd1,
        ARB_BUSY_IF  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fixed-priority arbiter sharing one RAM port between fetch and load/store
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = ARB_ADDR_W,
    parameter int DATA_W = ARB_DATA_W,
    parameter int SEL_W  = ARB_SEL_W
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    output logic              if_stall,
    input  logic              flush,

    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [SEL_W-1:0]  mem_sel,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_valid,
    output logic              mem_stall,

    output logic              ram_req,
    output logic              ram_we,
    output logic [SEL_W-1:0]  ram_sel,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic              ram_ack,
    input  logic [DATA_W-1:0] ram_rdata
);

    arb_state_t state;
    // Set when a branch flush hits a fetch that is granted or in flight;
    // that fetch still completes on the RAM side but its result is thrown away.
    logic       drop;

    // Stall a requester until the cycle its valid pulse is seen
    assign mem_stall = mem_req & ~mem_valid;
    assign if_stall  = if_req & ~if_valid;

    // Grant, RAM handshake and result return; every output here is registered,
    // so ram_ack/ram_rdata never reach ram_* combinationally
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ARB_IDLE;
            drop      <= 1'b0;
            ram_req   <= 1'b0;
            ram_we    <= 1'b0;
            ram_sel   <= '0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            if_rdata  <= '0;
            if_valid  <= 1'b0;
            mem_rdata <= '0;
            mem_valid <= 1'b0;
        end else begin
            if_valid  <= 1'b0;
            mem_valid <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    // A requester still high in its own valid cycle is not re-granted
                    if (mem_req && !mem_valid) begin
                        state     <= ARB_BUSY_MEM;
                        ram_req   <= 1'b1;
                        ram_we    <= mem_we;
                        ram_sel   <= mem_sel;
                        ram_addr  <= mem_addr;
                        ram_wdata <= mem_wdata;
                    end else if (if_req && !if_valid) begin
                        state     <= ARB_BUSY_IF;
                        ram_req   <= 1'b1;
                        ram_we    <= 1'b0;
                        ram_sel   <= '1;
                        ram_addr  <= if_addr;
                        ram_wdata <= '0;
                        drop      <= flush;
                    end
                end
                ARB_BUSY_MEM: begin
                    if (ram_ack) begin
                        state     <= ARB_IDLE;
                        ram_req   <= 1'b0;
                        mem_valid <= 1'b1;
                        if (!ram_we) begin
                            mem_rdata <= ram_rdata;
                        end
                    end
                end
                ARB_BUSY_IF: begin
                    if (flush) begin
                        drop <= 1'b1;
                    end
                    if (ram_ack) begin
                        state    <= ARB_IDLE;
                        ram_req  <= 1'b0;
                        if_rdata <= ram_rdata;
                        if_valid <= ~(drop | flush);
                        drop     <= 1'b0;
                    end
                end
                default: begin
                    state   <= ARB_IDLE;
                    ram_req <= 1'b0;
                    drop    <= 1'b0;
                end
            endcase
        end
    end

endmodule
